// File: rtl/register_file_pc.sv
// Register file with two combinational read ports, one write port and a
// self-incrementing PC mapped at the top address. Define RF_BYPASS_EN for write-through reads.
module register_file_pc #(
    parameter int W        = 17,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0,
    parameter int PC_STEP  = 1,
    parameter int PC_RESET = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          WE,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    input  logic [AW-1:0] A3,
    input  logic [W-1:0]  data,
    input  logic          PC_EN,
    output logic [W-1:0]  PC,
    output logic [W-1:0]  RD1,
    output logic [W-1:0]  RD2
);

    localparam int            DEPTH  = 2 ** AW;
    localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);

    logic [W-1:0]  pc_reg;
    logic [W-1:0]  pc_next;
    logic [W-1:0]  rf_word [DEPTH];
    logic          wr_drop;
    logic          wr_gp;
    logic          wr_pc;
    logic [AW-1:0] rd_addr [2];
    logic [W-1:0]  rd_data [2];

    // Writes to R0 vanish when it is hardwired to zero; PC writes are never dropped.
    assign wr_drop = (ZERO_REG != 0) && (A3 == '0);
    assign wr_pc   = WE && (A3 == PC_IDX);
    assign wr_gp   = WE && (A3 != PC_IDX) && !wr_drop;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign rf_word[gi] = '0;
            end else begin : g_flop
                logic [W-1:0] word_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        word_reg <= '0;
                    end else if (wr_gp && (A3 == AW'(gi))) begin
                        word_reg <= data;
                    end
                end
                assign rf_word[gi] = word_reg;
            end
        end
    endgenerate

    // The PC occupies the top slot so reads of PC_IDX fall out of the same mux.
    assign rf_word[DEPTH-1] = pc_reg;

    // Explicit write beats increment; the increment wraps silently.
    always_comb begin
        pc_next = pc_reg;
        if (wr_pc) begin
            pc_next = data;
        end else if (PC_EN) begin
            pc_next = pc_reg + W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= W'(PC_RESET);
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign PC = pc_reg;

    assign rd_addr[0] = A1;
    assign rd_addr[1] = A2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [W-1:0] port_val;
            always_comb begin
                port_val = rf_word[rd_addr[gi]];
`ifdef RF_BYPASS_EN
                // Only real writes are forwarded; an increment-only PC update is not.
                if ((wr_gp || wr_pc) && (rd_addr[gi] == A3)) begin
                    port_val = data;
                end
`endif
            end
            assign rd_data[gi] = port_val;
        end
    endgenerate

    assign RD1 = rd_data[0];
    assign RD2 = rd_data[1];

endmodule
